// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer handshake and status of the 8N1 receiver
interface uart_rx_if;
  logic       rxd;
  logic       read;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;
  modport master (output rxd, read, input data, valid, framing_err, overrun, busy);
  modport slave (input rxd, read, output data, valid, framing_err, overrun, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, holding register and framing/overrun flags
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rxd_s;
  assign rxd_s = sync_q[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~bus.read;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d          = '0;
        shift_d[idx_q] = rxd_s;
        idx_d          = idx_q + 3'd1;
        state_d        = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : BREAK;
        ferr_d  = ~rxd_s;
        data_d  = rxd_s ? shift_q : data_q;
        valid_d = rxd_s | valid_d;
        // a load coinciding with read consumes the old byte, so no overrun
        ovr_d   = rxd_s & valid_q & ~bus.read;
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun     = ovr_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: serializer-driven scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;
  typedef struct {
    logic [7:0] data;
    logic       ovr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  logic busy_prev = 1'b0;
  exp_t sb[$];
  uart_rx_if bus();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic send_bits(input logic [9:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovr  = o;
    sb.push_back(e);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pulse_read();
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, bus.data, 8'h00);
    check({tag, "_valid"}, bus.valid, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_ferr"}, bus.framing_err, 1'b0);
    check({tag, "_ovr"}, bus.overrun, 1'b0);
  endtask
  // a good frame finishes on the same edge that drops busy and loads data
  always @(negedge clk) begin
    if (bus.framing_err) ferr_cycles++;
    if (bus.overrun) ovr_cycles++;
    if (busy_prev && !bus.busy && bus.valid && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("load_data", bus.data, e.data);
      check("load_ovr", bus.overrun, e.ovr);
      check("load_ferr", bus.framing_err, 1'b0);
    end
    busy_prev = bus.busy;
  end
  initial begin
    bus.rxd  = 1'b1;
    bus.read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst");
    repeat (5) @(negedge clk);
    push(8'hA5, 1'b0);
    send_bits({1'b1, 8'hA5, 1'b0}, 10);
    check("basic_data", bus.data, 8'hA5);
    check("basic_valid", bus.valid, 1'b1);
    pulse_read();
    check("basic_read_clr", bus.valid, 1'b0);
    pulse_reset();
    bus.rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", bus.busy, 1'b1);
    repeat (20) @(negedge clk);
    check("glitch_idle", bus.busy, 1'b0);
    check("glitch_valid", bus.valid, 1'b0);
    check("glitch_data", bus.data, 8'h00);
    pulse_reset();
    send_bits({1'b0, 8'h3C, 1'b0}, 10);
    repeat (40) @(negedge clk);
    check("ferr_width", ferr_cycles, 1);
    check("ferr_data", bus.data, 8'h00);
    check("ferr_valid", bus.valid, 1'b0);
    check("ferr_busy", bus.busy, 1'b1);
    bus.rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_exit", bus.busy, 1'b0);
    push(8'h3C, 1'b0);
    send_bits({1'b1, 8'h3C, 1'b0}, 10);
    check("ferr_next_data", bus.data, 8'h3C);
    check("ferr_next_valid", bus.valid, 1'b1);
    pulse_read();
    push(8'h11, 1'b0);
    push(8'h22, 1'b1);
    send_bits({1'b1, 8'h11, 1'b0}, 10);
    send_bits({1'b1, 8'h22, 1'b0}, 10);
    check("ovr_count", ovr_cycles, 1);
    check("ovr_data", bus.data, 8'h22);
    check("ovr_valid", bus.valid, 1'b1);
    pulse_read();
    push(8'h00, 1'b0);
    send_bits({1'b1, 8'h00, 1'b0}, 10);
    check("coin_pre_valid", bus.valid, 1'b1);
    push(8'hFF, 1'b0);
    fork
      send_bits({1'b1, 8'hFF, 1'b0}, 10);
      begin
        repeat (CPB * 9 + 10) @(negedge clk);
        pulse_read();
        check("coin_data", bus.data, 8'hFF);
        check("coin_valid", bus.valid, 1'b1);
        check("coin_ovr", bus.overrun, 1'b0);
      end
    join
    send_bits({1'b1, 8'h55, 1'b0}, 5);
    bus.rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    pulse_reset();
    check_reset_outputs("midrst");
    repeat (40) @(negedge clk);
    push(8'h7E, 1'b0);
    send_bits({1'b1, 8'h7E, 1'b0}, 10);
    check("after_rst_data", bus.data, 8'h7E);
    check("after_rst_valid", bus.valid, 1'b1);
    check("sb_empty", sb.size(), 0);
    check("ovr_total", ovr_cycles, 1);
    check("ferr_total", ferr_cycles, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
